// File: rtl/phys_regfile_2w4r_if.sv
// Bundle between the writeback arbiter / rename / issue side (master) and the
// physical register file (slave).
//   wr_first_*  : arbiter first write stream (valid, address, data)
//   wr_second_* : arbiter second write stream (valid, address, data)
//   alloc_*     : rename destination allocation (marks register busy)
//   recover     : misprediction recovery (marks every register ready)
//   rdN_*       : read port N = 0..3 (valid/address in; data/data_valid/ready out)
interface phys_regfile_2w4r_if #(
  parameter int unsigned REG_ADDR_WIDTH = 6,
  parameter int unsigned REG_DATA_WIDTH = 64
);
  logic                      wr_first_valid;
  logic [REG_ADDR_WIDTH-1:0] wr_first_address;
  logic [REG_DATA_WIDTH-1:0] wr_first_data;
  logic                      wr_second_valid;
  logic [REG_ADDR_WIDTH-1:0] wr_second_address;
  logic [REG_DATA_WIDTH-1:0] wr_second_data;
  logic                      alloc_valid;
  logic [REG_ADDR_WIDTH-1:0] alloc_address;
  logic                      recover;

  logic                      rd0_valid, rd1_valid, rd2_valid, rd3_valid;
  logic [REG_ADDR_WIDTH-1:0] rd0_address, rd1_address, rd2_address, rd3_address;
  logic [REG_DATA_WIDTH-1:0] rd0_data, rd1_data, rd2_data, rd3_data;
  logic                      rd0_data_valid, rd1_data_valid, rd2_data_valid, rd3_data_valid;
  logic                      rd0_ready, rd1_ready, rd2_ready, rd3_ready;

  modport master (
    output wr_first_valid, wr_first_address, wr_first_data,
    output wr_second_valid, wr_second_address, wr_second_data,
    output alloc_valid, alloc_address, recover,
    output rd0_valid, rd1_valid, rd2_valid, rd3_valid,
    output rd0_address, rd1_address, rd2_address, rd3_address,
    input  rd0_data, rd1_data, rd2_data, rd3_data,
    input  rd0_data_valid, rd1_data_valid, rd2_data_valid, rd3_data_valid,
    input  rd0_ready, rd1_ready, rd2_ready, rd3_ready
  );

  modport slave (
    input  wr_first_valid, wr_first_address, wr_first_data,
    input  wr_second_valid, wr_second_address, wr_second_data,
    input  alloc_valid, alloc_address, recover,
    input  rd0_valid, rd1_valid, rd2_valid, rd3_valid,
    input  rd0_address, rd1_address, rd2_address, rd3_address,
    output rd0_data, rd1_data, rd2_data, rd3_data,
    output rd0_data_valid, rd1_data_valid, rd2_data_valid, rd3_data_valid,
    output rd0_ready, rd1_ready, rd2_ready, rd3_ready
  );
endinterface

// File: rtl/phys_regfile_2w4r.sv
// Flop-based physical register file: two write ports from the writeback
// arbiter, four registered read ports with write-first bypass, and a per-register
// ready scoreboard (busy on alloc, ready on writeback, all ready on recover).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : phys_regfile_2w4r_if.slave (write, alloc, recover and read ports)
// Register 0 is hardwired to zero and always ready.
module phys_regfile_2w4r #(
  parameter int unsigned REG_ADDR_WIDTH = 6,
  parameter int unsigned REG_DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  phys_regfile_2w4r_if.slave   bus
);
  localparam int unsigned DEPTH = 1 << REG_ADDR_WIDTH;
  localparam int unsigned NRD   = 4;

  logic [REG_DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]          ready_q;
  logic [DEPTH-1:0]          ready_d;

  logic                      rd_valid   [NRD];
  logic [REG_ADDR_WIDTH-1:0] rd_addr    [NRD];
  logic [REG_DATA_WIDTH-1:0] byp_data   [NRD];
  logic                      rd_ready_c [NRD];
  logic [REG_DATA_WIDTH-1:0] rd_data_q  [NRD];
  logic                      rd_dv_q    [NRD];

  // Index 0 is excluded here so writes/alloc to it never touch state.
  logic wa_en, wb_en, al_en;
  assign wa_en = bus.wr_first_valid  && (bus.wr_first_address  != '0);
  assign wb_en = bus.wr_second_valid && (bus.wr_second_address != '0);
  assign al_en = bus.alloc_valid     && (bus.alloc_address     != '0);

  assign rd_valid[0] = bus.rd0_valid;  assign rd_addr[0] = bus.rd0_address;
  assign rd_valid[1] = bus.rd1_valid;  assign rd_addr[1] = bus.rd1_address;
  assign rd_valid[2] = bus.rd2_valid;  assign rd_addr[2] = bus.rd2_address;
  assign rd_valid[3] = bus.rd3_valid;  assign rd_addr[3] = bus.rd3_address;

  // Ready next-state: writeback sets, alloc then clears, recover overrides all.
  always_comb begin
    ready_d = ready_q;
    if (wa_en) ready_d[bus.wr_first_address]  = 1'b1;
    if (wb_en) ready_d[bus.wr_second_address] = 1'b1;
    if (al_en) ready_d[bus.alloc_address]     = 1'b0;
    if (bus.recover) ready_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= '1;
    else     ready_q <= ready_d;
  end

  // Data storage; port B is applied last so it wins a same-index collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else begin
      if (wa_en) regs[bus.wr_first_address]  <= bus.wr_first_data;
      if (wb_en) regs[bus.wr_second_address] <= bus.wr_second_data;
    end
  end

  // Write-first bypass and combinational ready per read port.
  always_comb begin
    for (int n = 0; n < int'(NRD); n++) begin
      logic hit_a, hit_b;
      hit_a = wa_en && (bus.wr_first_address  == rd_addr[n]);
      hit_b = wb_en && (bus.wr_second_address == rd_addr[n]);
      byp_data[n] = regs[rd_addr[n]];
      if (hit_a) byp_data[n] = bus.wr_first_data;
      if (hit_b) byp_data[n] = bus.wr_second_data;
      if (rd_addr[n] == '0) byp_data[n] = '0;
      rd_ready_c[n] = ready_q[rd_addr[n]] | hit_a | hit_b;
    end
  end

  // Registered read responses; data holds when the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < int'(NRD); n++) begin
        rd_data_q[n] <= '0;
        rd_dv_q[n]   <= 1'b0;
      end
    end else begin
      for (int n = 0; n < int'(NRD); n++) begin
        rd_dv_q[n] <= rd_valid[n];
        if (rd_valid[n]) rd_data_q[n] <= byp_data[n];
      end
    end
  end

  assign bus.rd0_data = rd_data_q[0];  assign bus.rd0_data_valid = rd_dv_q[0];
  assign bus.rd1_data = rd_data_q[1];  assign bus.rd1_data_valid = rd_dv_q[1];
  assign bus.rd2_data = rd_data_q[2];  assign bus.rd2_data_valid = rd_dv_q[2];
  assign bus.rd3_data = rd_data_q[3];  assign bus.rd3_data_valid = rd_dv_q[3];

  assign bus.rd0_ready = rd_ready_c[0];
  assign bus.rd1_ready = rd_ready_c[1];
  assign bus.rd2_ready = rd_ready_c[2];
  assign bus.rd3_ready = rd_ready_c[3];
endmodule

// File: tb/tb_phys_regfile_2w4r.sv
// Scoreboard bench for phys_regfile_2w4r: directed scenarios followed by random
// traffic, checked against an array-based register file model.
module tb_phys_regfile_2w4r;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 64;
  localparam int unsigned NRD   = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phys_regfile_2w4r_if #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) bus ();

  phys_regfile_2w4r #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic          wav, wbv, alv, rec;
  logic [AW-1:0] waa, wba, ala;
  logic [DW-1:0] wad, wbd;
  logic          rv  [NRD];
  logic [AW-1:0] ra  [NRD];
  logic [DW-1:0] od  [NRD];
  logic          ov  [NRD];
  logic          ordy[NRD];

  assign bus.wr_first_valid    = wav;
  assign bus.wr_first_address  = waa;
  assign bus.wr_first_data     = wad;
  assign bus.wr_second_valid   = wbv;
  assign bus.wr_second_address = wba;
  assign bus.wr_second_data    = wbd;
  assign bus.alloc_valid       = alv;
  assign bus.alloc_address     = ala;
  assign bus.recover           = rec;
  assign bus.rd0_valid = rv[0];  assign bus.rd0_address = ra[0];
  assign bus.rd1_valid = rv[1];  assign bus.rd1_address = ra[1];
  assign bus.rd2_valid = rv[2];  assign bus.rd2_address = ra[2];
  assign bus.rd3_valid = rv[3];  assign bus.rd3_address = ra[3];
  assign od[0] = bus.rd0_data;  assign ov[0] = bus.rd0_data_valid;  assign ordy[0] = bus.rd0_ready;
  assign od[1] = bus.rd1_data;  assign ov[1] = bus.rd1_data_valid;  assign ordy[1] = bus.rd1_ready;
  assign od[2] = bus.rd2_data;  assign ov[2] = bus.rd2_data_valid;  assign ordy[2] = bus.rd2_ready;
  assign od[3] = bus.rd3_data;  assign ov[3] = bus.rd3_data_valid;  assign ordy[3] = bus.rd3_ready;

  // Reference model: architectural contents, ready bits, last returned data.
  logic [DW-1:0] mdata [DEPTH];
  logic          mrdy  [DEPTH];
  logic [DW-1:0] mlast [NRD];

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } exp_t;
  exp_t expq [NRD][$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int port, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s port%0d @%0t: got 0x%0h expected 0x%0h", name, port, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wbv && wba == a) return wbd;
    if (wav && waa == a) return wad;
    return mdata[a];
  endfunction

  function automatic logic m_ready(input logic [AW-1:0] a);
    if (a == 0) return 1'b1;
    return mrdy[a] | (wav && waa == a) | (wbv && wba == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mdata[i] = '0;
      mrdy[i]  = 1'b1;
    end
    for (int n = 0; n < int'(NRD); n++) mlast[n] = '0;
  endtask

  task automatic clear_inputs();
    wav = 1'b0; waa = '0; wad = '0;
    wbv = 1'b0; wba = '0; wbd = '0;
    alv = 1'b0; ala = '0; rec = 1'b0;
    for (int n = 0; n < int'(NRD); n++) begin
      rv[n] = 1'b0;
      ra[n] = '0;
    end
  endtask

  task automatic preload_queues();
    exp_t e;
    e.v = 1'b0;
    e.d = '0;
    for (int n = 0; n < int'(NRD); n++) begin
      expq[n].delete();
      expq[n].push_back(e);
    end
  endtask

  // One clock with the currently driven inputs; entered and left at posedge+1.
  task automatic step();
    exp_t e;
    for (int n = 0; n < int'(NRD); n++) begin
      if (rv[n]) mlast[n] = m_read(ra[n]);
      e.v = rv[n];
      e.d = mlast[n];
      expq[n].push_back(e);
    end
    @(negedge clk);
    for (int n = 0; n < int'(NRD); n++)
      chk("rd_ready", n, DW'(ordy[n]), DW'(m_ready(ra[n])));
    @(posedge clk);
    if (wav && waa != 0) begin mdata[waa] = wad; mrdy[waa] = 1'b1; end
    if (wbv && wba != 0) begin mdata[wba] = wbd; mrdy[wba] = 1'b1; end
    if (alv && ala != 0) mrdy[ala] = 1'b0;
    if (rec) for (int i = 0; i < int'(DEPTH); i++) mrdy[i] = 1'b1;
    #1;
  endtask

  // Monitor: one response per port per cycle, in issue order.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int n = 0; n < int'(NRD); n++) begin
        if (expq[n].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty port%0d @%0t: got valid=%0d expected an entry", n, $time, ov[n]);
        end else begin
          e = expq[n].pop_front();
          chk("rd_data_valid", n, DW'(ov[n]), DW'(e.v));
          chk("rd_data", n, od[n], e.d);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    #12;
    for (int n = 0; n < int'(NRD); n++) begin
      chk("reset_data_valid", n, DW'(ov[n]), '0);
      chk("reset_data", n, od[n], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    preload_queues();
    mon_en = 1'b1;

    // Read after reset.
    rv[0] = 1'b1; ra[0] = 6'd5; step(); clear_inputs();
    // Write via A, read next cycle.
    wav = 1'b1; waa = 6'd5; wad = 64'hDEAD; step(); clear_inputs();
    rv[1] = 1'b1; ra[1] = 6'd5; step(); clear_inputs();
    // A/B collision with same-cycle read; then re-read.
    wav = 1'b1; waa = 6'd7; wad = 64'h11;
    wbv = 1'b1; wba = 6'd7; wbd = 64'h22;
    rv[2] = 1'b1; ra[2] = 6'd7; step(); clear_inputs();
    rv[2] = 1'b1; ra[2] = 6'd7; step(); clear_inputs();
    // Alloc then writeback bypass on ready.
    alv = 1'b1; ala = 6'd9; step(); clear_inputs();
    ra[3] = 6'd9; step(); clear_inputs();
    wbv = 1'b1; wba = 6'd9; wbd = 64'h33; rv[3] = 1'b1; ra[3] = 6'd9; step(); clear_inputs();
    rv[3] = 1'b1; ra[3] = 6'd9; step(); clear_inputs();
    // Alloc + write same index, then recover.
    alv = 1'b1; ala = 6'd4; wav = 1'b1; waa = 6'd4; wad = 64'h44; ra[0] = 6'd4; step(); clear_inputs();
    rv[0] = 1'b1; ra[0] = 6'd4; rec = 1'b1; step(); clear_inputs();
    rv[0] = 1'b1; ra[0] = 6'd4; step(); clear_inputs();
    // Register 0 is hardwired.
    wav = 1'b1; waa = 6'd0; wad = 64'hFF; alv = 1'b1; ala = 6'd0; rv[1] = 1'b1; ra[1] = 6'd0;
    step(); clear_inputs();
    rv[0] = 1'b1; ra[0] = 6'd0; rv[1] = 1'b1; ra[1] = 6'd0; step(); clear_inputs();

    // Random traffic on a small index window to force collisions.
    for (int c = 0; c < 400; c++) begin
      wav = ($urandom_range(0, 99) < 50); waa = AW'($urandom_range(0, 15)); wad = {$urandom, $urandom};
      wbv = ($urandom_range(0, 99) < 50); wba = AW'($urandom_range(0, 15)); wbd = {$urandom, $urandom};
      alv = ($urandom_range(0, 99) < 30); ala = AW'($urandom_range(0, 15));
      rec = ($urandom_range(0, 99) < 4);
      for (int n = 0; n < int'(NRD); n++) begin
        rv[n] = ($urandom_range(0, 99) < 60);
        ra[n] = AW'($urandom_range(0, 15));
      end
      step();
    end
    clear_inputs();

    // Reset with a read in flight.
    wav = 1'b1; waa = 6'd10; wad = 64'hABCD_0123; step(); clear_inputs();
    for (int n = 0; n < int'(NRD); n++) begin rv[n] = 1'b1; ra[n] = 6'd10; end
    step(); clear_inputs();
    rv[2] = 1'b1; ra[2] = 6'd10;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    for (int n = 0; n < int'(NRD); n++) begin
      chk("midreset_data_valid", n, DW'(ov[n]), '0);
      chk("midreset_data", n, od[n], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    preload_queues();
    mon_en = 1'b1;
    for (int n = 0; n < int'(NRD); n++) begin rv[n] = 1'b1; ra[n] = 6'd10; end
    step(); clear_inputs();
    step();
    step();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phys_regfile_2w4r.md
Name: phys_regfile_2w4r

Overview:
- Physical register file directly downstream of the 7-to-2 writeback arbiter.
- Accepts the arbiter's two selected write streams (first/second) and serves four registered read ports to issue.
- Keeps a per-register ready (busy) scoreboard: set busy on rename allocation, cleared by writeback, bulk-cleared on recovery.

Parameters:
- REG_ADDR_WIDTH, 6, physical register index width; depth = 2^REG_ADDR_WIDTH.
- REG_DATA_WIDTH, 64, register data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_first_valid  in  1  write port A enable (arbiter first output).
- wr_first_address  in  REG_ADDR_WIDTH  write port A index.
- wr_first_data  in  REG_DATA_WIDTH  write port A data.
- wr_second_valid  in  1  write port B enable (arbiter second output).
- wr_second_address  in  REG_ADDR_WIDTH  write port B index.
- wr_second_data  in  REG_DATA_WIDTH  write port B data.
- alloc_valid  in  1  rename allocates a destination register.
- alloc_address  in  REG_ADDR_WIDTH  register to mark busy.
- recover  in  1  misprediction recovery; marks every register ready.
- rdN_valid  in  1  read request, N = 0..3.
- rdN_address  in  REG_ADDR_WIDTH  read index, N = 0..3.
- rdN_data  out  REG_DATA_WIDTH  registered read data, N = 0..3.
- rdN_data_valid  out  1  rdN_data holds a valid response, N = 0..3.
- rdN_ready  out  1  combinational ready status of rdN_address, N = 0..3.

Behaviour:
- Reset (async, rst=1): every data entry = 0; every ready bit = 1; all rdN_data = 0; all rdN_data_valid = 0. Reset mid-operation discards in-flight reads. No output is valid until the first edge after rst deasserts.
- Register 0 is hardwired:
  - reads always return 0;
  - rd ready is always 1;
  - writes and alloc to index 0 are ignored.
- Write:
  - On each edge, every valid port writes its data to its index and sets that index's ready bit to 1.
  - If A and B target the same nonzero index in one cycle, B wins for data. The arbiter normally prevents this.
- Alloc:
  - alloc_valid clears the ready bit of alloc_address on the edge.
  - If alloc and a write target the same index in the same cycle: data is written, and ready ends 0 (alloc wins).
- Recover:
  - Sets all ready bits to 1 on the edge.
  - Overrides a same-cycle alloc.
  - Data is untouched.
- Read:
  - 1-cycle latency. rdN_address is sampled when rdN_valid = 1; rdN_data and rdN_data_valid = 1 appear after the edge.
  - When rdN_valid = 0, rdN_data_valid = 0 next cycle and rdN_data holds its previous value.
  - Write-first: a read of an index written in the same cycle returns the new write data. If both ports hit the index, port B data is returned.
- rdN_ready (combinational) = stored ready bit OR (a same-cycle valid write to rdN_address).
  - A same-cycle alloc is not seen until the next cycle.
- All four read ports are independent; any number may read the same index.
- Storage is flop-based (no SRAM macro) so the same-cycle bypass is exact.

Test Plan:
- Reset then read p5 on rd0 -> rd0_data = 0, rd0_data_valid = 1 one cycle later; rd0_ready = 1.
- Write p5 = 0xDEAD via port A, read p5 on rd1 the next cycle -> rd1_data = 0xDEAD after one cycle.
- Same cycle: port A writes p7 = 0x11, port B writes p7 = 0x22, rd2 reads p7 -> rd2_data = 0x22; p7 holds 0x22 afterwards.
- alloc p9, then rd3 checks p9 -> rd3_ready = 0. In a later cycle port B writes p9 = 0x33: rd3_ready = 1 in that same cycle (bypass), stays 1 after.
- alloc p4 and port A writes p4 = 0x44 in the same cycle -> p4 ready = 0, data = 0x44. Next cycle: recover -> p4 ready = 1.
- Write p0 = 0xFF, then read p0 -> returns 0, ready = 1. Assert rst while a read is in flight -> rdN_data_valid = 0 immediately and all data = 0.
